byte_cmd_serializer: RTL and testbench

- Host-side transmitter for the byte ingress command protocol. It serializes 24-bit write-address / 32-bit write-data commands into the byte stream that drives the core's ID/IValid inputs.
- Used in loopback test harnesses and in the planned on-chip host/bridge that feeds ClkIngress-domain cores.
- Contains a small command FIFO, a frame-serializing FSM, inter-frame gap insertion and Rdyn backpressure.

---
 rtl/byte_cmd_serializer.sv | 149 ++++++++++++++
 tb/tb_byte_cmd_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/byte_cmd_serializer.sv
// Host-side byte ingress command serializer.
// Buffers {WriteAddr, WriteData} commands in a small FIFO and emits each as a
// 7-byte frame (addr[23:16], addr[15:8], addr[7:0], data[31:24] .. data[7:0])
// on Data/DataValid, honouring Rdyn backpressure and an inter-frame gap.
// Ports:
//   ClkIngress      - clock, rising edge
//   ARst            - synchronous active-high reset
//   WriteAddr/WriteData/WriteDataValid - command offer
//   CmdReady        - FIFO not full (combinational)
//   Level           - FIFO occupancy (registered)
//   Data/DataValid  - serialized byte stream (registered)
//   Rdyn            - downstream busy (active-low ready)
//   Busy            - FSM active or FIFO non-empty
module byte_cmd_serializer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FIFO_AW    = 2,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic               ClkIngress,
    input  logic               ARst,
    input  logic [23:0]        WriteAddr,
    input  logic [31:0]        WriteData,
    input  logic               WriteDataValid,
    output logic               CmdReady,
    output logic [FIFO_AW:0]   Level,
    output logic [7:0]         Data,
    output logic               DataValid,
    input  logic               Rdyn,
    output logic               Busy
);

    localparam int unsigned CMD_W       = 56;
    localparam int unsigned CNT_W       = FIFO_AW + 1;
    localparam int unsigned FRAME_BYTES = 7;
    localparam int unsigned GAP_W       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_GAP
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [CMD_W-1:0]     mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CMD_W-1:0]     shift;
    logic [2:0]           idx;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 rdyn_q;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 emit;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push     = WriteDataValid & ~full;
    assign CmdReady = ~full;
    assign Level    = count;
    assign Busy     = (state != S_IDLE) | ~empty;

    // Next-state and per-cycle strobes; backpressure uses the registered Rdyn.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        emit       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    next_state = S_LOAD;
                    pop        = 1'b1;
                end
            end
            S_LOAD: begin
                // Shift register was filled on entry, so the first byte can
                // leave on the edge that exits LOAD.
                next_state = S_SEND;
                emit       = ~rdyn_q;
            end
            S_SEND: begin
                if (!rdyn_q) begin
                    emit = 1'b1;
                    if (idx == 3'(FRAME_BYTES - 1)) begin
                        next_state = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES)) begin
                    if (!empty) begin
                        next_state = S_LOAD;
                        pop        = 1'b1;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State, FIFO bookkeeping and output byte registers.
    always_ff @(posedge ClkIngress) begin
        if (ARst) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            shift     <= '0;
            idx       <= '0;
            gap_cnt   <= '0;
            rdyn_q    <= 1'b0;
            Data      <= 8'h00;
            DataValid <= 1'b0;
        end else begin
            state     <= next_state;
            rdyn_q    <= Rdyn;
            DataValid <= emit;

            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);

            if (pop) begin
                shift <= mem[rd_ptr];
                idx   <= '0;
            end else if (emit) begin
                shift <= {shift[CMD_W-9:0], 8'h00};
                idx   <= idx + 3'd1;
            end

            if (emit) Data <= shift[CMD_W-1:CMD_W-8];

            if (state == S_GAP && next_state == S_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
            else                                       gap_cnt <= '0;
        end
    end

    // Command storage; contents need no reset since pointers gate every read.
    always_ff @(posedge ClkIngress) begin
        if (!ARst && push) mem[wr_ptr] <= {WriteAddr, WriteData};
    end

endmodule

// File: tb/tb_byte_cmd_serializer.sv
// Directed bench for byte_cmd_serializer: scoreboard of expected bytes filled
// on command acceptance, drained by a negedge monitor. A second instance with
// GAP_CYCLES=0 shares the inputs and is only checked in the last phase.
module tb_byte_cmd_serializer;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [23:0] waddr = '0;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        rdyn = 1'b0;

    logic        cmd_ready, data_valid, busy;
    logic [2:0]  level;
    logic [7:0]  data;
    logic        cmd_ready0, data_valid0, busy0;
    logic [2:0]  level0;
    logic [7:0]  data0;

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          mon0_en = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp0_q[$];
    int          dv_cyc[$];
    int          dv0_cyc[$];

    byte_cmd_serializer #(.FIFO_DEPTH(4), .FIFO_AW(2), .GAP_CYCLES(1)) dut (
        .ClkIngress(clk), .ARst(arst), .WriteAddr(waddr), .WriteData(wdata),
        .WriteDataValid(wvalid), .CmdReady(cmd_ready), .Level(level), .Data(data),
        .DataValid(data_valid), .Rdyn(rdyn), .Busy(busy)
    );

    byte_cmd_serializer #(.FIFO_DEPTH(4), .FIFO_AW(2), .GAP_CYCLES(0)) dut0 (
        .ClkIngress(clk), .ARst(arst), .WriteAddr(waddr), .WriteData(wdata),
        .WriteDataValid(wvalid), .CmdReady(cmd_ready0), .Level(level0), .Data(data0),
        .DataValid(data_valid0), .Rdyn(rdyn), .Busy(busy0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitors: every valid byte must match the head of its scoreboard.
    always @(negedge clk) begin
        if (data_valid) begin
            dv_cyc.push_back(cyc);
            if (exp_q.size() != 0) chk("byte", 32'(data), 32'(exp_q.pop_front()));
            else                   chk("extra_byte_q_size", 32'(exp_q.size()), 32'd1);
        end
        if (mon0_en && data_valid0) begin
            dv0_cyc.push_back(cyc);
            if (exp0_q.size() != 0) chk("byte_gap0", 32'(data0), 32'(exp0_q.pop_front()));
            else                    chk("extra_byte_gap0_q_size", 32'(exp0_q.size()), 32'd1);
        end
    end

    task automatic push_cmd(input logic [23:0] a, input logic [31:0] d, output int acc);
        logic [55:0] cmd;
        bit          rdy;
        bit          done;
        cmd    = {a, d};
        done   = 1'b0;
        acc    = -1;
        waddr  = a;
        wdata  = d;
        wvalid = 1'b1;
        for (int k = 0; k < 80 && !done; k++) begin
            rdy = cmd_ready;
            @(negedge clk);
            if (rdy) begin
                done = 1'b1;
                acc  = cyc;
                for (int i = 0; i < 7; i++) begin
                    exp_q.push_back(cmd[55-8*i -: 8]);
                    if (mon0_en) exp0_q.push_back(cmd[55-8*i -: 8]);
                end
            end
        end
        wvalid = 1'b0;
        chk("push_accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int k = 0; k < budget && dv_cyc.size() < n; k++) begin
            @(negedge clk);
            #1;
        end
        chk("byte_count_reached", 32'(dv_cyc.size() >= n), 32'd1);
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && (exp_q.size() != 0 || exp0_q.size() != 0); k++) begin
            @(negedge clk);
            #1;
        end
        chk("scoreboard_drained", 32'(exp_q.size() + exp0_q.size()), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && busy; k++) begin
            @(negedge clk);
            #1;
        end
        chk("idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int a0, a1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_dv", 32'(data_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        arst = 1'b0;
        @(negedge clk);

        // Single command: latency 2 to first byte, 7 consecutive bytes, Busy drops after gap
        dv_cyc.delete();
        push_cmd(24'h00_0104, 32'hDEAD_BEEF, a0);
        drain(40);
        if (dv_cyc.size() == 7) begin
            chk("first_byte_latency", 32'(dv_cyc[0] - a0), 32'd2);
            chk("last_byte_latency", 32'(dv_cyc[6] - a0), 32'd8);
        end
        while (cyc < a0 + 9) @(negedge clk);
        #1 chk("busy_in_gap", 32'(busy), 32'd1);
        @(negedge clk);
        #1 chk("busy_after_gap", 32'(busy), 32'd0);

        // Backpressure: Rdyn high for 3 cycles once the first byte is out
        wait_idle(20);
        dv_cyc.delete();
        push_cmd(24'h00_0104, 32'hDEAD_BEEF, a0);
        wait_bytes(1, 20);
        rdyn = 1'b1;
        repeat (3) @(negedge clk);
        rdyn = 1'b0;
        drain(40);
        repeat (4) @(negedge clk);
        chk("bp_byte_total", 32'(dv_cyc.size()), 32'd7);
        if (dv_cyc.size() == 7) begin
            chk("bp_gap_01_04", 32'(dv_cyc[2] - dv_cyc[1]), 32'd4);
            chk("bp_tail_contiguous", 32'(dv_cyc[6] - dv_cyc[2]), 32'd4);
            chk("bp_head_contiguous", 32'(dv_cyc[1] - dv_cyc[0]), 32'd1);
        end

        // FIFO full: 5 back-to-back pushes under stall, 6th held until a pop
        wait_idle(20);
        rdyn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            push_cmd(24'(4 * i), {8'hA0 + 8'(i), 8'hB0 + 8'(i), 8'hC0 + 8'(i), 8'hD0 + 8'(i)}, a0);
        end
        chk("full_level", 32'(level), 32'd4);
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        waddr  = 24'h14;
        wdata  = 32'hA5B5C5D5;
        wvalid = 1'b1;
        repeat (3) @(negedge clk);
        chk("full_hold_level", 32'(level), 32'd4);
        chk("full_hold_ready", 32'(cmd_ready), 32'd0);
        rdyn = 1'b0;
        push_cmd(24'h14, 32'hA5B5C5D5, a0);
        drain(120);

        // Simultaneous push and pop: second push lands on the IDLE->LOAD pop edge
        wait_idle(20);
        push_cmd(24'h12_3456, 32'h0102_0304, a0);
        chk("pre_pop_level", 32'(level), 32'd1);
        push_cmd(24'h65_4321, 32'hF0E0_D0C0, a1);
        chk("b2b_accept", 32'(a1 - a0), 32'd1);
        chk("simul_level", 32'(level), 32'd1);
        drain(60);

        // Reset mid-frame with two commands queued
        wait_idle(20);
        dv_cyc.delete();
        push_cmd(24'h000100, 32'h1111_1111, a0);
        push_cmd(24'h000200, 32'h2222_2222, a0);
        push_cmd(24'h000300, 32'h3333_3333, a0);
        wait_bytes(3, 20);
        arst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_dv", 32'(data_valid), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        exp_q.delete();
        arst = 1'b0;
        repeat (15) @(negedge clk);
        chk("no_bytes_after_reset", 32'(dv_cyc.size()), 32'd3);
        push_cmd(24'hAB_CDEF, 32'h1234_5678, a0);
        drain(40);

        // GAP_CYCLES=0 vs 1: two queued commands, Rdyn=0
        arst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        exp0_q.delete();
        arst = 1'b0;
        @(negedge clk);
        dv_cyc.delete();
        dv0_cyc.delete();
        mon0_en = 1'b1;
        push_cmd(24'h00_0010, 32'h5566_7788, a0);
        push_cmd(24'h00_0020, 32'h99AA_BBCC, a1);
        drain(60);
        chk("gap0_byte_total", 32'(dv0_cyc.size()), 32'd14);
        if (dv0_cyc.size() == 14) begin
            chk("gap0_first_latency", 32'(dv0_cyc[0] - a0), 32'd2);
            chk("gap0_span", 32'(dv0_cyc[13] - dv0_cyc[0]), 32'd14);
            chk("gap0_interframe", 32'(dv0_cyc[7] - dv0_cyc[6]), 32'd2);
        end
        if (dv_cyc.size() == 14) begin
            chk("gap1_interframe", 32'(dv_cyc[7] - dv_cyc[6]), 32'd3);
        end
        chk("gap1_byte_total", 32'(dv_cyc.size()), 32'd14);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
